// File: rtl/mod_n_up_counter.sv
// Synchronous modulo-MOD up-counter with count enable, range-checked parallel load,
// combinational terminal count (for cascading) and registered wrap / load-error pulses.
//
// Optional feature: define MOD_N_UP_WRAPCNT_EN to add a saturating wrap counter
// (parameter WC_W, output wrap_cnt). With the macro undefined neither exists.

module mod_n_up_counter #(
    parameter int unsigned MOD  = 10,
    parameter int unsigned W    = 4
`ifdef MOD_N_UP_WRAPCNT_EN
    ,
    parameter int unsigned WC_W = 8
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [W-1:0]    load_val,
    output logic [W-1:0]    count,
    output logic            tc,
    output logic            wrap,
    output logic            load_err
`ifdef MOD_N_UP_WRAPCNT_EN
    ,
    output logic [WC_W-1:0] wrap_cnt
`endif
);

    // Reject illegal configurations at elaboration time.
    if (MOD < 2) begin : g_bad_mod
        $error("mod_n_up_counter: MOD must be >= 2");
    end
    if ((W < 32) && (MOD > (32'd1 << W))) begin : g_bad_width
        $error("mod_n_up_counter: W too narrow, need 2**W >= MOD");
    end

    localparam logic [W-1:0] Last = W'(MOD - 1);

    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         load_err_q, load_err_d;
    logic         load_in_range;
    logic         count_out_range;

    assign load_in_range   = (32'(load_val) < MOD);
    // Only reachable if the register was forced (e.g. X resolution); recovered on next count.
    assign count_out_range = (32'(count_q) >= MOD);

    // Next-state decode: load beats enable; reset is applied in the register block.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_in_range) begin
                count_d = load_val;
            end else begin
                count_d    = '0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (count_q == Last) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else if (count_out_range) begin
                count_d = '0;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Terminal count is combinational so a following stage can count on the same edge.
    always_comb begin
        tc = (count_q == Last) && en && !load;
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

`ifdef MOD_N_UP_WRAPCNT_EN
    logic [WC_W-1:0] wrap_cnt_q;

    // Saturating count of wrap events; only reset clears it, load leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt_q <= '0;
        end else if (wrap_d && (wrap_cnt_q != {WC_W{1'b1}})) begin
            wrap_cnt_q <= wrap_cnt_q + WC_W'(1);
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: doc/mod_n_up_counter.md
Name: mod_n_up_counter

Overview:
- Synchronous modulo-MOD up-counter: counts 0, 1, ..., MOD-1, then wraps to 0.
- Companion to the team's mod-n down-counter.
- Used as a cycle or event divider where ascending phase order is needed.
- Adds count-enable, synchronous parallel load with range check, and terminal-count/wrap flags so instances can cascade into multi-digit counters.

Parameters:
- MOD, 10, counting modulus; legal range MOD >= 2.
- W, 4, counter width in bits; must satisfy 2^W >= MOD. Elaboration error if violated.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; advance by one on clk when high.
- load  input  1  synchronous parallel load strobe.
- load_val  input  W  value written on load.
- count  output  W  registered current count.
- tc  output  1  combinational terminal count: (count == MOD-1) && en && !load.
- wrap  output  1  registered one-cycle pulse; high the cycle after a count MOD-1 -> 0 transition.
- load_err  output  1  registered one-cycle pulse; high the cycle after a load with load_val >= MOD.

Behaviour:
- Reset is synchronous, active-high, on clk; clock is clk.
- Reset values: count = 0, wrap = 0, load_err = 0. tc evaluates to 0 during and after reset, because count = 0 (MOD >= 2).
- Priority per rising clk edge: rst > load > en > hold.
- rst = 1: all registers take their reset values, regardless of load or en.
- load = 1, rst = 0:
  - load_val < MOD: count <= load_val, load_err <= 0.
  - load_val >= MOD: count <= 0, load_err <= 1.
  - In both cases wrap <= 0, even if en = 1 and count == MOD-1.
- en = 1, load = 0, rst = 0:
  - count < MOD-1: count <= count + 1, wrap <= 0.
  - count == MOD-1: count <= 0, wrap <= 1.
- en = 0, load = 0, rst = 0: count holds; wrap <= 0, load_err <= 0.
- Both wrap and load_err are single-cycle pulses. They never stay high for two consecutive cycles unless the triggering event repeats on consecutive edges. Example: with MOD = 2 and en held high, wrap is high every other cycle.
- Latency:
  - count reflects load or increment one cycle after the edge.
  - tc is zero-latency (combinational) so a following stage can use it as its en on the same edge.
  - wrap is one cycle late relative to tc.
- Cascading: connecting stage k+1's en to stage k's tc yields a correct multi-digit counter with no extra delay.
- Arithmetic: the increment is W bits wide. Its carry-out is never used because count never exceeds MOD-1 after a legal load. For MOD = 2^W, wrap-around is the natural roll-over and must still produce wrap.
- Out-of-range state: count >= MOD is unreachable. If it is ever forced, e.g. by X-resolution in simulation, the next enabled edge must drive count to 0.
- Reset mid-operation: rst asserted at any count returns count to 0 on that edge. Any pending pulse is cleared.

Optional Feature:
- Macro: MOD_N_UP_WRAPCNT_EN.
- When defined:
  - Adds parameter WC_W (default 8).
  - Adds output wrap_cnt [WC_W-1:0], reset to 0.
  - wrap_cnt increments on each edge where the counter wraps MOD-1 -> 0, i.e. on the same edge that sets wrap.
  - wrap_cnt saturates at 2^WC_W - 1 and does not roll over.
  - wrap_cnt is cleared only by rst; load does not affect it.
- When not defined: no wrap_cnt port, no extra registers. Behaviour is otherwise identical.

Test Plan:
- Reset then en = 1 for 12 cycles, MOD = 10:
  - count = 0,1,...,9,0,1.
  - tc high only while count = 9.
  - wrap high exactly one cycle, the cycle count reads 0.
- Load checks, MOD = 10:
  - load = 1, load_val = 7, en = 1 -> count = 7 next cycle, no wrap.
  - load_val = 12 -> count = 0, load_err = 1 for exactly one cycle.
- Load priority, MOD = 10: count = 9, en = 1, load = 1, load_val = 3 -> count = 3, wrap = 0; tc = 0 during that cycle.
- Enable and reset interaction, MOD = 10:
  - en toggled 1,0,1,0 from count = 8 -> count 9, 9, 0, 0; wrap pulses once.
  - rst asserted at count = 5 with en = 1 -> count = 0 next cycle.
- Cascade and roll-over:
  - Two instances, MOD = 10, stage 1 en = stage 0 tc, 100 cycles -> count pair runs 00 to 99, then wraps to 00; stage 1 wrap fires once.
  - MOD = 16, W = 4 -> 15 rolls over to 0 with wrap asserted.
- MOD_N_UP_WRAPCNT_EN defined, WC_W = 2, MOD = 3, 15 enabled cycles -> wrap_cnt = 1,2,3 and then holds at 3; rst clears it to 0.
